// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch FIFO feeding the decoder; `PREFETCH_STATS_EN adds flush_count
module inst_prefetch #(
    parameter int RAM_SIZE = 256,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        jmp_inst,
    input  logic [7:0]  jmp_address,
    input  logic        hlt_inst,
    output logic        halted
`ifdef PREFETCH_STATS_EN
    , output logic [15:0] flush_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] MASK = 8'(RAM_SIZE - 1);
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {FETCH, STALL, HALTING, HALTED} state_t;
    state_t state, state_n;

    logic [31:0]   fifo_w  [DEPTH];
    logic [7:0]    fifo_pc [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_n;
    logic [CW-1:0] count, cnt_after_pop, cnt_n;
    logic [CW:0]   level;
    logic [7:0]    fetch_pc, rsp_pc, head_pc;
    logic [31:0]   head_w;
    logic          inflight, jmp_eff, pop, push, issue;

    // issue/pop/push decisions, next head selection and state transitions
    always_comb begin
        jmp_eff       = jmp_inst && state != HALTED;
        pop           = ir_valid && ir_ready && !jmp_eff;
        push          = inflight && !jmp_eff;
        level         = {1'b0, count} + (CW+1)'(inflight);
        issue         = !reset && state == FETCH && level < FULL && !jmp_inst && !hlt_inst;
        cnt_after_pop = count - CW'(pop);
        cnt_n         = cnt_after_pop + CW'(push);
        rd_n          = rd_ptr + PW'(pop);
        head_w        = cnt_after_pop == '0 ? mem_rdata : fifo_w[rd_n];
        head_pc       = cnt_after_pop == '0 ? rsp_pc : fifo_pc[rd_n];
        mem_rd        = issue;
        mem_addr      = fetch_pc;
        halted        = state == HALTED;
        state_n       = state;
        if (state == HALTING)
            state_n = inflight ? HALTING : HALTED;
        else if (state != HALTED && hlt_inst)
            state_n = HALTING;
        else if (state == FETCH && level == FULL && !pop && !jmp_inst)
            state_n = STALL;
        else if (state == STALL && (pop || jmp_inst))
            state_n = FETCH;
    end

    // control state, fetch pointer, FIFO pointers and registered head view
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= '0;
            rsp_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_n;
            inflight <= issue;
            if (issue) begin
                rsp_pc   <= fetch_pc;
                fetch_pc <= (fetch_pc + 8'd1) & MASK;
            end
            if (jmp_eff) begin
                fetch_pc <= jmp_address & MASK;
                rd_ptr   <= wr_ptr;
                count    <= '0;
                ir_valid <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                rd_ptr   <= rd_n;
                count    <= cnt_n;
                ir_valid <= cnt_n != '0;
                if (cnt_n != '0) begin
                    ir    <= head_w;
                    ir_pc <= head_pc;
                end
            end
        end
    end

    // FIFO storage: returning word with the address it was fetched from
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_w[wr_ptr]  <= mem_rdata;
            fifo_pc[wr_ptr] <= rsp_pc;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [16:0] flush_sum;

    // buffered entries plus the word arriving this cycle are lost on a jump
    always_comb flush_sum = 17'(flush_count) + 17'(count) + 17'(inflight);

    // saturating count of words discarded by jumps
    always_ff @(posedge clk) begin
        if (reset)
            flush_count <= '0;
        else if (jmp_eff)
            flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
`endif
endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
Instruction prefetch stage that sits directly upstream of the instruction decoder/cpu_core.
- Reads 32-bit instruction words from the synchronous program RAM.
- Buffers them, with their addresses, in a small FIFO.
- Presents the head word as `ir`, using a valid/ready handshake to the decoder.
- A taken jump from the decoder flushes the buffer and redirects fetch.
- A halt freezes fetch.

Parameters:
- RAM_SIZE, 256, number of 32-bit words in program RAM; power of two, 2..256.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- mem_rd  output  1  RAM read strobe; data returns exactly 1 cycle later.
- mem_addr  output  8  RAM word address.
- mem_rdata  input  32  RAM read data, valid the cycle after mem_rd.
- ir  output  32  head instruction word.
- ir_pc  output  8  address of the head word.
- ir_valid  output  1  head entry present.
- ir_ready  input  1  decoder consumes the head this cycle.
- jmp_inst  input  1  taken jump, flush and redirect.
- jmp_address  input  8  jump target.
- hlt_inst  input  1  halt request, sticky until reset.
- halted  output  1  halt is active and no read is in flight.

Behaviour:
- Reset values:
  - mem_rd=0, mem_addr=0, ir=0, ir_pc=0, ir_valid=0, halted=0.
  - fetch_pc=0, FIFO empty, inflight=0, drop=0, state=FETCH.
- Addresses are masked to log2(RAM_SIZE) bits. fetch_pc increments modulo RAM_SIZE, so RAM_SIZE-1 wraps to 0.
- Issue rule: mem_rd=1 when all of the following hold, with mem_addr=fetch_pc:
  - state==FETCH;
  - (count + inflight) < DEPTH;
  - jmp_inst==0.
  - On issue, fetch_pc increments.
  - At most one read is in flight.
- Response: the cycle after an issue, if drop==0, push {mem_rdata, issued address}.
- Pop: when ir_valid && ir_ready, the head is removed. ir/ir_pc/ir_valid are registered views of the head.
- Push and pop in the same cycle leave count unchanged.
- Push into an empty FIFO appears on ir the following cycle. First-word latency after reset or jump is therefore 2 cycles (issue, push, then visible).
- Jump (jmp_inst=1):
  - count:=0 and ir_valid:=0 next cycle.
  - fetch_pc := jmp_address (masked).
  - If a read is in flight, drop:=1 so that response is discarded.
  - No issue occurs in the jump cycle.
  - Jump has priority over pop and push in the same cycle.
  - A jump while HALTED is ignored.
- State machine:
  - FETCH: issues reads per the issue rule.
  - FETCH -> STALL when count+inflight==DEPTH and no pop.
  - STALL -> FETCH on pop or jump.
  - FETCH/STALL -> HALTING on hlt_inst. No new issue occurs; the in-flight response is still pushed. The FIFO keeps draining to the decoder.
  - HALTING -> HALTED once inflight==0. halted=1 from that point.
  - HALTED: exited only by reset.
- Reset mid-operation: any in-flight response arriving the cycle after reset is discarded (drop is forced to 1 on reset if inflight).
- ir_ready while ir_valid==0 has no effect. The FIFO never overflows (guaranteed by the issue rule).

Optional Feature:
- PREFETCH_STATS_EN defined:
  - Adds output `flush_count` (16 bits): number of valid entries plus in-flight words discarded by jumps.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Fill: RAM[0..5]=32'h1000_0000+i, ir_ready=0.
  - mem_rd is high for exactly 4 cycles (addr 0..3), then stalls.
  - ir=32'h1000_0000, ir_pc=0, ir_valid=1 from cycle 3.
- Stream: hold ir_ready=1.
  - After startup, one word per cycle with ir_pc 0,1,2,3,4,5 in order.
  - No gaps, no duplicates.
- Jump with a read in flight: jmp_inst=1, jmp_address=8'h20 while the FIFO holds 3 entries and a read is in flight.
  - Next cycle ir_valid=0; the stale response is not pushed.
  - The next issued mem_addr=8'h20.
  - First ir_pc after the jump is 8'h20.
  - With PREFETCH_STATS_EN: flush_count=4.
- Wrap: RAM_SIZE=16, jmp_address=8'h0F, ir_ready=1.
  - ir_pc sequence is 0x0F, 0x00, 0x01.
- Halt: assert hlt_inst with 2 entries buffered and 1 read in flight.
  - No further mem_rd.
  - All 3 words are delivered.
  - halted=1 after the in-flight read returns.
  - A subsequent jmp_inst is ignored.
- Reset mid-operation: assert reset in the cycle a read is in flight.
  - The next cycle all outputs are at reset values and nothing is pushed.
  - Fetch restarts at addr 0.
